// File: rtl/cross_ctrl_enc.sv
// Crossbar control encoder: turns an NUM_IN x NUM_IN one-hot control matrix back into
// per-output source indices, with column error flags and a permutation check.
module cross_ctrl_enc #(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned DW_IDX = 3,
    parameter int unsigned DW_CNT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_IN*NUM_IN-1:0]   ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_IN*DW_IDX-1:0]   idx,
    output logic [NUM_IN-1:0]          col_err,
    output logic                       perm_ok,
    output logic [DW_CNT-1:0]          err_cnt
);

    localparam int unsigned NM = NUM_IN * NUM_IN;
    localparam int unsigned CW = $clog2(NUM_IN + 1);

    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s1_adv;
    logic                     s2_adv;
    logic [NM-1:0]            s1_ctrl;
    logic [NUM_IN*DW_IDX-1:0] enc_idx;
    logic [NUM_IN-1:0]        enc_err;
    logic                     enc_dup;
    logic                     enc_perm;
    logic [CW-1:0]            col_cnt;

    // Stage advance: in_ready is combinational from out_ready through s2_adv.
    always_comb begin
        s2_adv    = !s2_valid || out_ready;
        s1_adv    = !s1_valid || s2_adv;
        in_ready  = s1_adv;
        out_valid = s2_valid;
    end

    // Column encode: descending row scan so the last write is the lowest set row.
    always_comb begin
        enc_idx  = '0;
        enc_err  = '0;
        enc_dup  = 1'b0;
        enc_perm = 1'b0;
        col_cnt  = '0;
        for (int j = 0; j < int'(NUM_IN); j++) begin
            col_cnt = '0;
            for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
                if (s1_ctrl[i*int'(NUM_IN)+j]) begin
                    col_cnt                      = col_cnt + CW'(1);
                    enc_idx[j*DW_IDX +: DW_IDX] = DW_IDX'(i);
                end
            end
            enc_err[j] = (col_cnt != CW'(1));
        end
        for (int a = 0; a < int'(NUM_IN); a++) begin
            for (int b = a + 1; b < int'(NUM_IN); b++) begin
                if (enc_idx[a*DW_IDX +: DW_IDX] == enc_idx[b*DW_IDX +: DW_IDX]) begin
                    enc_dup = 1'b1;
                end
            end
        end
        enc_perm = !(|enc_err) && !enc_dup;
    end

    // Raw matrix capture; contents are irrelevant while s1_valid is low.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_ctrl <= ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            idx      <= '0;
            col_err  <= '0;
            perm_ok  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                // A frame loads S2 exactly once, so the error count never double counts.
                if (s1_valid) begin
                    idx     <= enc_idx;
                    col_err <= enc_err;
                    perm_ok <= enc_perm;
                    if ((|enc_err) && (err_cnt != {DW_CNT{1'b1}})) begin
                        err_cnt <= err_cnt + DW_CNT'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cross_ctrl_enc.sv
// Randomized bench for cross_ctrl_enc against a queue-based frame model,
// plus a narrow-counter instance for saturation.
module tb_cross_ctrl_enc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] idx;
    logic [7:0]  col_err;
    logic        perm_ok;
    logic [15:0] err_cnt;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [63:0] s_ctrl;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [23:0] s_idx;
    logic [7:0]  s_col_err;
    logic        s_perm_ok;
    logic [2:0]  s_err_cnt;

    cross_ctrl_enc #(.NUM_IN(8), .DW_IDX(3), .DW_CNT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .idx(idx), .col_err(col_err),
        .perm_ok(perm_ok), .err_cnt(err_cnt)
    );

    cross_ctrl_enc #(.NUM_IN(8), .DW_IDX(3), .DW_CNT(3)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .ctrl(s_ctrl),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .idx(s_idx), .col_err(s_col_err),
        .perm_ok(s_perm_ok), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] idx;
        logic [7:0]  err;
        logic        perm;
        logic [15:0] cnt;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_bad;
    int   n_edge;
    int   bad_frames;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    // Reference: list the set rows of each column; the first one listed is the source.
    function automatic exp_t ref_enc(input logic [63:0] m);
        exp_t e;
        int   rows[$];
        bit   seen[8];
        bit   dup;
        logic [2:0] v;
        e.idx = '0;
        e.err = '0;
        e.cnt = '0;
        e.acc = 0;
        dup   = 0;
        for (int k = 0; k < 8; k++) seen[k] = 0;
        for (int j = 0; j < 8; j++) begin
            rows.delete();
            for (int i = 0; i < 8; i++) if (m[i*8+j]) rows.push_back(i);
            if (rows.size() != 1) e.err[j] = 1'b1;
            if (rows.size() > 0) e.idx[j*3 +: 3] = 3'(rows[0]);
        end
        for (int j = 0; j < 8; j++) begin
            v = e.idx[j*3 +: 3];
            if (seen[v]) dup = 1;
            seen[v] = 1;
        end
        e.perm = (e.err == 8'h00) && !dup;
        return e;
    endfunction

    function automatic logic [63:0] perm_mat();
        int p[8];
        int t;
        int r;
        logic [63:0] m;
        for (int i = 0; i < 8; i++) p[i] = i;
        for (int i = 7; i > 0; i--) begin
            r = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[r]; p[r] = t;
        end
        m = '0;
        for (int j = 0; j < 8; j++) m[p[j]*8+j] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] rand_mat();
        logic [63:0] m;
        int kind;
        kind = int'($urandom_range(0, 3));
        m = perm_mat();
        if (kind == 2) m[$urandom_range(0, 63)] ^= 1'b1;
        if (kind == 3) begin
            m = '0;
            for (int b = 0; b < 64; b++) m[b] = ($urandom_range(0, 7) == 0);
        end
        return m;
    endfunction

    // One cycle: drive at negedge, check against the model, then account for the edge.
    task automatic step(input logic v, input logic [63:0] c, input logic rdy, output logic fired);
        exp_t f;
        logic exp_ov;
        logic exp_ir;
        logic ofire;
        in_valid  = v;
        ctrl      = c;
        out_ready = rdy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].acc < n_edge);
        exp_ir = (q.size() < 2) || rdy;
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        if (exp_ov) begin
            f = q[0];
            chk("idx", 64'(idx), 64'(f.idx));
            chk("col_err", 64'(col_err), 64'(f.err));
            chk("perm_ok", 64'(perm_ok), 64'(f.perm));
            chk("err_cnt", 64'(err_cnt), 64'(f.cnt));
        end
        fired = v && exp_ir;
        ofire = exp_ov && rdy;
        @(posedge clk);
        n_edge++;
        if (ofire) void'(q.pop_front());
        if (fired) begin
            f = ref_enc(c);
            if ((|f.err) && bad_frames < 65535) bad_frames++;
            f.cnt = 16'(bad_frames);
            f.acc = n_edge;
            q.push_back(f);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        logic fd;
        for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0, '0, 1'b1, fd);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    logic [63:0] m;
    logic [63:0] frames[4];
    logic        fd;
    int          k;
    int          rt[8];

    initial begin
        clk = 0; rst = 1; in_valid = 0; ctrl = '0; out_ready = 0;
        s_in_valid = 0; s_ctrl = '0; s_out_ready = 1;
        n_chk = 0; n_bad = 0; n_edge = 0; bad_frames = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_col_err", 64'(col_err), 64'd0);
        chk("rst_perm_ok", 64'(perm_ok), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 0;

        // Identity: handshake first possible two edges after acceptance.
        m = '0;
        for (int i = 0; i < 8; i++) m[i*8+i] = 1'b1;
        step(1'b1, m, 1'b1, fd);
        step(1'b0, '0, 1'b1, fd);
        #1;
        chk("id_idx", 64'(idx), 64'h00FAC688);
        chk("id_perm", 64'(perm_ok), 64'd1);
        drain();

        // Round trip of the decoder pattern {0,0,1,1,2,2,3,3} (col7..col0).
        rt = '{3, 3, 2, 2, 1, 1, 0, 0};
        m = '0;
        for (int j = 0; j < 8; j++) m[rt[j]*8+j] = 1'b1;
        step(1'b1, m, 1'b1, fd);
        step(1'b0, '0, 1'b1, fd);
        #1;
        chk("rt_idx", 64'(idx), 64'h0000949B);
        chk("rt_perm", 64'(perm_ok), 64'd0);
        drain();

        // Column 3 empty, column 5 with rows 2 and 6.
        m = '0;
        for (int i = 0; i < 8; i++) m[i*8+i] = 1'b1;
        m[3*8+3] = 1'b0; m[5*8+5] = 1'b0; m[2*8+5] = 1'b1; m[6*8+5] = 1'b1;
        step(1'b1, m, 1'b1, fd);
        step(1'b0, '0, 1'b1, fd);
        #1;
        chk("c3_col_err", 64'(col_err), 64'h28);
        chk("c3_err_cnt", 64'(err_cnt), 64'd1);
        drain();

        // Four frames with out_ready low for cycles 2..5.
        for (int i = 0; i < 4; i++) frames[i] = rand_mat();
        k = 0;
        for (int c = 0; c < 40 && (k < 4 || q.size() > 0); c++) begin
            step(k < 4, (k < 4) ? frames[k] : 64'd0, !(c >= 2 && c <= 5), fd);
            if (fd) k++;
        end
        chk("stall_sent", 64'(k), 64'd4);
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, rand_mat(), $urandom_range(0, 3) != 0, fd);
        end
        drain();

        // Reset with both stages full of bad frames.
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, fd);
        chk("full_err_cnt_nz", 64'(err_cnt != 16'd0), 64'd1);
        rst = 1; in_valid = 0;
        @(posedge clk);
        n_edge++;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 0;
        q.delete();
        bad_frames = 0;
        for (int c = 0; c < 30; c++) step(1'b1, rand_mat(), 1'b1, fd);
        drain();

        // Narrow counter: 5 bad frames count, 12 more saturate at 7.
        s_in_valid = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        s_in_valid = 0;
        repeat (3) @(negedge clk);
        chk("sat_mid", 64'(s_err_cnt), 64'd5);
        s_in_valid = 1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        s_in_valid = 0;
        repeat (3) @(negedge clk);
        chk("sat_hold", 64'(s_err_cnt), 64'd7);
        chk("sat_col_err", 64'(s_col_err), 64'hFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
